// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves the D-stage branch prediction in EX, issues a one-shot
//            redirect/flush on a wrong guess and trains the predictor.
//            Optional perf counters enabled by defining BRU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int PC_W  = 32
`ifdef BRU_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallD,
    input  logic            stallE,
    input  logic            flush_ext,
    input  logic            branchD,
    input  logic            pred_takeD,
    input  logic [PC_W-1:0] pcD,
    input  logic [PC_W-1:0] targetD,
    input  logic            actual_takeE,
    output logic            pred_errorE,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush_front,
    output logic            upd_valid,
    output logic [PC_W-1:0] upd_pc,
    output logic            upd_taken
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_brE;
    logic            r_predE;
    logic [PC_W-1:0] r_pcE;
    logic [PC_W-1:0] r_targetE;

    logic            w_idle;
    logic            w_updFire;
    logic [PC_W-1:0] w_pcPlus4;

    assign w_idle    = (r_state == IDLE);
    assign w_pcPlus4 = r_pcE + PC_W'(4);

    assign pred_errorE    = r_brE & ~stallE & w_idle & (actual_takeE != r_predE);
    assign redirect_valid = pred_errorE;
    assign flush_front    = pred_errorE;
    assign redirect_pc    = actual_takeE ? r_targetE : w_pcPlus4;

    // Every resolved branch trains, right or wrong; an external flush kills it.
    assign w_updFire = r_brE & ~stallE & w_idle & ~flush_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_brE     <= 1'b0;
            r_predE   <= 1'b0;
            r_pcE     <= '0;
            r_targetE <= '0;
            r_state   <= IDLE;
            upd_valid <= 1'b0;
            upd_pc    <= '0;
            upd_taken <= 1'b0;
        end else begin
            if (!stallE) begin
                if (flush_front || flush_ext || stallD) begin
                    r_brE     <= 1'b0;
                    r_predE   <= 1'b0;
                    r_pcE     <= '0;
                    r_targetE <= '0;
                end else begin
                    r_brE     <= branchD;
                    r_predE   <= pred_takeD;
                    r_pcE     <= pcD;
                    r_targetE <= targetD;
                end
            end

            case (r_state)
                IDLE:    if (pred_errorE) r_state <= RECOVER;
                RECOVER: if (!stallE)     r_state <= IDLE;
                default:                  r_state <= IDLE;
            endcase

            upd_valid <= w_updFire;
            if (w_updFire) begin
                upd_pc    <= r_pcE;
                upd_taken <= actual_takeE;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (upd_valid && (br_cnt != '1))       br_cnt  <= br_cnt + CNT_W'(1);
            if (redirect_valid && (mis_cnt != '1)) mis_cnt <= mis_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed redirect/update vectors.
`default_nettype none

module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallD = 1'b0;
    logic        stallE = 1'b0;
    logic        flush_ext = 1'b0;
    logic        branchD = 1'b0;
    logic        pred_takeD = 1'b0;
    logic [31:0] pcD = '0;
    logic [31:0] targetD = '0;
    logic        actual_takeE = 1'b0;
    logic        pred_errorE;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_front;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;
`endif

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stallD        (stallD),
        .stallE        (stallE),
        .flush_ext     (flush_ext),
        .branchD       (branchD),
        .pred_takeD    (pred_takeD),
        .pcD           (pcD),
        .targetD       (targetD),
        .actual_takeE  (actual_takeE),
        .pred_errorE   (pred_errorE),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush_front   (flush_front),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken)
`ifdef BRU_PERF_CNT_EN
        ,
        .br_cnt        (br_cnt),
        .mis_cnt       (mis_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic putD(input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        branchD    = 1'b1;
        pcD        = pc;
        targetD    = tgt;
        pred_takeD = pred;
    endtask

    task automatic clrD();
        branchD    = 1'b0;
        pcD        = '0;
        targetD    = '0;
        pred_takeD = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_updv", upd_valid, 0);
        chk("rst_updpc", upd_pc, 0);
        chk("rst_state", dut.r_state, 0);
        rst = 1'b1;
        step();

        // 1: correct taken prediction
        putD(32'h100, 32'h200, 1'b1);
        step();
        clrD();
        actual_takeE = 1'b1;
        #1;
        chk("t1_noredirect", redirect_valid, 0);
        chk("t1_noflush", flush_front, 0);
        step();
        chk("t1_updv", upd_valid, 1);
        chk("t1_updpc", upd_pc, 32'h100);
        chk("t1_updtaken", upd_taken, 1);
        step();
        chk("t1_updv_pulse", upd_valid, 0);
`ifdef BRU_PERF_CNT_EN
        chk("t1_brcnt", br_cnt, 1);
        chk("t1_miscnt", mis_cnt, 0);
`endif

        // 2: predicted taken, actually not taken
        putD(32'h100, 32'h200, 1'b1);
        step();
        clrD();
        actual_takeE = 1'b0;
        #1;
        chk("t2_redirect", redirect_valid, 1);
        chk("t2_perr", pred_errorE, 1);
        chk("t2_flush", flush_front, 1);
        chk("t2_rpc", redirect_pc, 32'h104);
        step();
        chk("t2_oneshot", flush_front, 0);
        chk("t2_state", dut.r_state, 1);
        chk("t2_updv", upd_valid, 1);
        chk("t2_updtaken", upd_taken, 0);
        step();
        chk("t2_idle", dut.r_state, 0);

        // 3: mispredict held by stallE for 3 cycles
        putD(32'h40, 32'h80, 1'b0);
        step();
        clrD();
        stallE = 1'b1;
        actual_takeE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_noredir", redirect_valid, 0);
            step();
            chk("t3_stall_noupd", upd_valid, 0);
        end
        stallE = 1'b0;
        #1;
        chk("t3_redirect", redirect_valid, 1);
        chk("t3_rpc", redirect_pc, 32'h80);
        step();
        chk("t3_once", redirect_valid, 0);
        chk("t3_updv", upd_valid, 1);
        chk("t3_updpc", upd_pc, 32'h40);
        step();

        // 4: mispredict at 0x10, branch at 0x14 behind it is squashed
        putD(32'h10, 32'h50, 1'b1);
        step();
        putD(32'h14, 32'h90, 1'b0);
        actual_takeE = 1'b0;
        #1;
        chk("t4_redirect", redirect_valid, 1);
        chk("t4_rpc", redirect_pc, 32'h14);
        step();
        clrD();
        chk("t4_squashed", dut.r_brE, 0);
        chk("t4_noredir2", redirect_valid, 0);
        chk("t4_updpc", upd_pc, 32'h10);
        chk("t4_updv", upd_valid, 1);
        step();
        chk("t4_one_pkt", upd_valid, 0);
        step();

        // 5: PC wrap on not-taken redirect
        putD(32'hFFFF_FFFC, 32'h1000, 1'b1);
        step();
        clrD();
        actual_takeE = 1'b0;
        #1;
        chk("t5_redirect", redirect_valid, 1);
        chk("t5_wrap", redirect_pc, 32'h0);
        step();
        step();

        // flush_ext together with a mispredict: redirect fires, update suppressed
        putD(32'h500, 32'h600, 1'b0);
        step();
        clrD();
        actual_takeE = 1'b1;
        flush_ext = 1'b1;
        #1;
        chk("fx_redirect", redirect_valid, 1);
        chk("fx_rpc", redirect_pc, 32'h600);
        step();
        flush_ext = 1'b0;
        chk("fx_noupd", upd_valid, 0);
        step();

        // back-to-back, first correct: second resolves next cycle
        putD(32'h300, 32'h380, 1'b1);
        step();
        putD(32'h304, 32'h390, 1'b0);
        actual_takeE = 1'b1;
        #1;
        chk("bb_noredir1", redirect_valid, 0);
        step();
        clrD();
        actual_takeE = 1'b0;
        #1;
        chk("bb_noredir2", redirect_valid, 0);
        chk("bb_upd1", upd_pc, 32'h300);
        step();
        chk("bb_updv2", upd_valid, 1);
        chk("bb_upd2", upd_pc, 32'h304);
        chk("bb_updtaken2", upd_taken, 0);
        step();

        // 6: reset while in RECOVER with upd_valid high
        putD(32'h700, 32'h800, 1'b1);
        step();
        clrD();
        actual_takeE = 1'b0;
        step();
        chk("t6_pre_state", dut.r_state, 1);
        chk("t6_pre_updv", upd_valid, 1);
        rst = 1'b0;
        #1;
        chk("t6_state", dut.r_state, 0);
        chk("t6_updv", upd_valid, 0);
        chk("t6_updpc", upd_pc, 0);
        chk("t6_updtaken", upd_taken, 0);
        chk("t6_redirect", redirect_valid, 0);
`ifdef BRU_PERF_CNT_EN
        chk("t6_brcnt", br_cnt, 0);
        chk("t6_miscnt", mis_cnt, 0);
`endif
        step();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
